dct_row_feeder: RTL and testbench



---
 rtl/dct_row_feeder_pkg.sv | 10 +
 rtl/dct_result_fifo.sv | 43 ++++
 rtl/dct_row_feeder.sv | 113 +++++++++++
 tb/tb_dct_row_feeder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_row_feeder_pkg.sv
// Shared widths and operand-bank type for the DCTQ row feeder.
package dct_row_feeder_pkg;
    localparam int unsigned DW      = 12;
    localparam int unsigned SW      = 15;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned ROW_LEN = 8;

    typedef logic [ROW_LEN-1:0][DW-1:0] bank_t;
endpackage

// File: rtl/dct_result_fifo.sv
// Synchronous FIFO holding tagged row sums until the consumer takes them.
module dct_result_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (wr_en && !do_rd)      count <= count + 1'b1;
            else if (!wr_en && do_rd) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/dct_row_feeder.sv
// Assembles serial samples into rows for the adder12s pipeline and returns tagged row sums.
module dct_row_feeder
    import dct_row_feeder_pkg::*;
#(
    parameter int unsigned RES_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    n0,
    output logic [DW-1:0]    n1,
    output logic [DW-1:0]    n2,
    output logic [DW-1:0]    n3,
    output logic [DW-1:0]    n4,
    output logic [DW-1:0]    n5,
    output logic [DW-1:0]    n6,
    output logic [DW-1:0]    n7,
    input  logic [SW-1:0]    sum,
    output logic [SW-1:0]    out_sum,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int unsigned PW = $clog2(RES_DEPTH + 1);

    bank_t              bank [2];
    bank_t              n_q;
    logic [1:0]         full;
    logic               wr_sel;
    logic               rd_sel;
    logic [ROW_W-1:0]   wr_ptr;
    logic               issue_q;
    logic [LATENCY-1:0] vld_sr;
    logic [PW-1:0]      pend;
    logic [ROW_W-1:0]   row_cnt;
    logic               accept;
    logic               fill_done;
    logic               issue;
    logic               pop;
    logic               fifo_empty;
    logic [ROW_W+SW-1:0] fifo_rd;

    assign in_ready  = !full[wr_sel];
    assign accept    = in_valid && in_ready;
    assign fill_done = accept && (wr_ptr == ROW_W'(ROW_LEN - 1));
    // pend covers in-flight rows plus FIFO entries, so capture can never overflow
    assign issue     = full[rd_sel] && (pend < PW'(RES_DEPTH));
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (accept) bank[wr_sel][wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_ptr  <= '0;
            issue_q <= 1'b0;
            vld_sr  <= '0;
            pend    <= '0;
            row_cnt <= '0;
            n_q     <= '0;
        end else begin
            issue_q <= issue;
            vld_sr  <= {vld_sr[LATENCY-2:0], issue_q};
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (fill_done) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (issue) begin
                n_q          <= bank[rd_sel];
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
            if (issue && !pop)      pend <= pend + 1'b1;
            else if (!issue && pop) pend <= pend - 1'b1;
            if (vld_sr[LATENCY-1]) row_cnt <= row_cnt + 1'b1;
        end
    end

    dct_result_fifo #(
        .WIDTH (ROW_W + SW),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_sr[LATENCY-1]),
        .wr_data ({row_cnt, sum}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_sum   = fifo_rd[SW-1:0];
    assign out_row   = fifo_rd[SW +: ROW_W];
    assign out_last  = (out_row == ROW_W'(ROW_LEN - 1));

    assign n0 = n_q[0];
    assign n1 = n_q[1];
    assign n2 = n_q[2];
    assign n3 = n_q[3];
    assign n4 = n_q[4];
    assign n5 = n_q[5];
    assign n6 = n_q[6];
    assign n7 = n_q[7];
endmodule

// File: tb/tb_dct_row_feeder.sv
// Directed self-checking bench for dct_row_feeder with a behavioural 5-stage adder12s model.
module tb_dct_row_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [14:0] sum;
    logic [14:0] out_sum;
    logic [2:0]  out_row;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    logic [18:0] got_q[$];
    logic [14:0] pipe [5];

    always #5 clk = ~clk;

    dct_row_feeder #(.RES_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n0        (n0),
        .n1        (n1),
        .n2        (n2),
        .n3        (n3),
        .n4        (n4),
        .n5        (n5),
        .n6        (n6),
        .n7        (n7),
        .sum       (sum),
        .out_sum   (out_sum),
        .out_row   (out_row),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [14:0] sx(input logic [11:0] v);
        return {{3{v[11]}}, v};
    endfunction

    // adder12s: captures operands on the edge after issue, sum valid 5 clocks later
    always @(posedge clk) begin
        pipe[0] <= sx(n0) + sx(n1) + sx(n2) + sx(n3) + sx(n4) + sx(n5) + sx(n6) + sx(n7);
        for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
    assign sum = pipe[4];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_row, out_sum});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] v);
        int w;
        in_data  = v;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
            stalls++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_row(input logic [11:0] v);
        for (int i = 0; i < 8; i++) push(v);
    endtask

    task automatic wait_results(input int n, input string tag);
        int w;
        w = 0;
        while (got_q.size() < n && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [11:0] row3 [8];

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_n0", 32'(n0), 32'd0);
        chk("rst_n7", 32'(n7), 32'd0);

        // 1: row of ones, issue and completion latency
        push_row(12'd1);
        w = 0;
        while (n0 !== 12'd1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("t1_issue_lat", 32'(w), 32'd1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("t1_valid_rise", 32'(w), 32'd6);
        chk("t1_out_sum", 32'(out_sum), 32'd8);
        chk("t1_out_row", 32'(out_row), 32'd0);
        chk("t1_out_last", 32'(out_last), 32'd0);
        wait_results(1, "t1_count");
        chk("t1_entry", 32'(got_q[0]), {13'd0, 1'b0, 3'd0, 15'd8});

        // 2: extremes
        got_q.delete();
        push_row(12'h800);
        push_row(12'h7FF);
        wait_results(2, "t2_count");
        chk("t2_min", 32'(got_q[0]), {13'd0, 1'b0, 3'd1, 15'h4000});
        chk("t2_max", 32'(got_q[1]), {13'd0, 1'b0, 3'd2, 15'h3FF8});

        // 3: mixed signs then ascending row
        got_q.delete();
        row3 = '{-12'sd5, 12'sd3, 12'sd7, -12'sd1, 12'sd0, 12'sd100, -12'sd100, 12'sd2};
        for (int i = 0; i < 8; i++) push(row3[i]);
        for (int i = 0; i < 8; i++) push(12'(i));
        wait_results(2, "t3_count");
        chk("t3_mixed", 32'(got_q[0]), {13'd0, 1'b0, 3'd3, 15'd6});
        chk("t3_ramp", 32'(got_q[1]), {13'd0, 1'b0, 3'd4, 15'd28});
        chk("t3_n5_hold", 32'(n5), 32'd5);
        chk("t3_n7_hold", 32'(n7), 32'd7);

        // 4: 16 rows streamed, row tags wrap and out_last on rows 7 and 15
        do_reset();
        stalls = 0;
        for (int r = 0; r < 16; r++) push_row(12'(r));
        wait_results(16, "t4_count");
        for (int r = 0; r < 16; r++)
            chk($sformatf("t4_row%0d", r), 32'(got_q[r]),
                {13'd0, 1'((r % 8) == 7), 3'(r % 8), 15'(8 * r)});
        chk("t4_no_stall", 32'(stalls), 32'd0);

        // 5: backpressure fills FIFO and both banks, then drains in order
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 10; r++) push_row(12'(r + 1));
        repeat (20) @(negedge clk);
        chk("t5_in_ready_low", 32'(in_ready), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd1);
        chk("t5_none_popped", 32'(got_q.size()), 32'd0);
        chk("t5_issue_stalled_n0", 32'(n0), 32'd8);
        in_data  = 12'd99;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_results(10, "t5_count");
        for (int r = 0; r < 10; r++)
            chk($sformatf("t5_row%0d", r), 32'(got_q[r]),
                {13'd0, 1'(r == 7), 3'(r % 8), 15'(8 * (r + 1))});
        repeat (20) @(negedge clk);
        chk("t5_no_extra", 32'(got_q.size()), 32'd10);
        chk("t5_in_ready_back", 32'(in_ready), 32'd1);
        chk("t5_drained", 32'(out_valid), 32'd0);

        // 6: reset with results buffered, a row in flight and a partial row
        do_reset();
        out_ready = 1'b0;
        push_row(12'd5);
        push_row(12'd6);
        push_row(12'd7);
        for (int i = 0; i < 3; i++) push(12'd9);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_n0", 32'(n0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        push_row(12'd2);
        wait_results(1, "t6_count");
        repeat (20) @(negedge clk);
        chk("t6_no_stale", 32'(got_q.size()), 32'd1);
        chk("t6_entry", 32'(got_q[0]), {13'd0, 1'b0, 3'd0, 15'd16});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
